// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   - the FSM state encoding
//   - the clock/baud constants that produce the default inter-frame gap
//     (one bit time at 27 MHz / 115200 baud, truncated to whole clocks)
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int CLK_HZ         = 27_000_000;
    localparam int BAUD_RATE      = 115_200;
    localparam int FRAME_GAP_CLKS = 234;

    // Whole clocks per serial bit; 27 MHz / 115200 truncates to 234.
    function automatic int clocks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority picker (purely combinational).
// Grants the first requesting index at or after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   in   NUM_REQ  request vector
//   ptr   in   PTR_W    highest-priority index this round (0..NUM_REQ-1)
//   pick  out  NUM_REQ  one-hot winner, zero when no request
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic found;
    int   idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr never exceeds NUM_REQ-1, so one subtraction wraps it.
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter in front of a UART serializer.
// One requester at a time owns the byte stream for a whole frame; bytes pass
// straight through with zero latency. Frames are separated by an idle gap,
// and a granted requester that withholds data too long is aborted.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   req        in   NUM_REQ    per-requester frame request (level)
//   req_data   in   8*NUM_REQ  per-requester byte, slice i = [8i+7:8i]
//   req_valid  in   NUM_REQ    per-requester byte valid
//   req_last   in   NUM_REQ    final byte of frame, qualified by req_valid
//   req_ready  out  NUM_REQ    byte accept, only ever on the granted bit
//   grant      out  NUM_REQ    one-hot frame owner, zero outside XFER
//   tx_data    out  8          byte to serializer
//   tx_valid   out  1          byte valid to serializer
//   tx_ready   in   1          serializer accept
//   abort      out  1          one-cycle pulse on stall timeout
//   busy       out  1          high whenever not IDLE
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int GAP_CYCLES  = FRAME_GAP_CLKS,
    parameter int STALL_LIMIT = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   abort,
    output logic                   busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    // The gap counter only has to reach GAP_CYCLES-1.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]         state;
    logic [PW-1:0]      gidx;
    logic [PW-1:0]      rr_ptr;
    logic [SW-1:0]      stall_cnt;
    logic [GW-1:0]      gap_cnt;

    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]      pick_idx;
    logic [PW-1:0]      next_ptr;
    logic [SW-1:0]      stall_inc;
    logic               gap_done;
    logic               fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // Zero-latency byte path; everything is forced to zero outside XFER so
    // nothing can leak to the serializer while no frame is owned.
    always_comb begin
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (state == ST_XFER) begin
            tx_data         = req_data[8*int'(gidx) +: 8];
            tx_valid        = req_valid[gidx];
            req_ready[gidx] = tx_ready;
        end
    end

    assign fire      = tx_valid & tx_ready;
    assign busy      = (state != ST_IDLE);
    assign stall_inc = stall_cnt + SW'(1);
    assign next_ptr  = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
    assign gap_done  = (GAP_CYCLES == 0) || (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (|req) begin
                        state     <= ST_XFER;
                        grant     <= pick;
                        gidx      <= pick_idx;
                        stall_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    // req[g] is deliberately not looked at: only the last
                    // byte or a stall timeout can end the frame.
                    if (fire) begin
                        stall_cnt <= '0;
                        if (req_last[gidx]) begin
                            state   <= ST_GAP;
                            grant   <= '0;
                            rr_ptr  <= next_ptr;
                            gap_cnt <= '0;
                        end
                    end else if (!tx_valid) begin
                        // Serializer backpressure is not a stall; only
                        // cycles with no byte offered count.
                        stall_cnt <= stall_inc;
                        if (stall_inc == SW'(STALL_LIMIT)) begin
                            abort   <= 1'b1;
                            state   <= ST_GAP;
                            grant   <= '0;
                            rr_ptr  <= next_ptr;
                            gap_cnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                        state   <= (|req) ? ST_ARB : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (3 requesters, 234-clock gap,
// stall limit 16). A frame-level model predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_uart_tx_arbiter;

    localparam int N     = 3;
    localparam int GAP   = 234;
    localparam int STALL = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_ready, abort, busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .GAP_CYCLES  (GAP),
        .STALL_LIMIT (STALL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .abort     (abort),
        .busy      (busy)
    );

    // Requester sources: each entry is {last, byte}.
    logic [8:0] q [N][$];
    logic [N-1:0] hold;
    logic [7:0] seen [$];
    int tests = 0;
    int fails = 0;
    int fires = 0;
    int cyc   = 0;
    bit bp    = 0;
    bit stab  = 0;
    bit prev_vnr = 0;
    logic [7:0] prev_data = 8'h00;

    // ---------------- frame-level model ----------------
    // owner: requester holding the stream, -1 if none.
    // quiet: idle clocks still owed after a frame.
    // arb_now: one arbitration cycle pending.
    int m_owner = -1;
    int m_next  = 0;
    int m_quiet = 0;
    int m_stall = 0;
    bit m_arb   = 0;
    bit m_abort = 0;

    always @(posedge clk or posedge rst) begin
        bit ended;
        ended = 0;
        if (rst) begin
            m_owner = -1; m_next = 0; m_quiet = 0; m_stall = 0;
            m_arb = 0; m_abort = 0;
        end else begin
            m_abort = 0;
            if (m_owner >= 0) begin
                if (req_valid[m_owner] && tx_ready) begin
                    m_stall = 0;
                    if (req_last[m_owner]) ended = 1;
                end else if (!req_valid[m_owner]) begin
                    m_stall = m_stall + 1;
                    if (m_stall == STALL) begin
                        m_abort = 1;
                        ended = 1;
                    end
                end
                if (ended) begin
                    m_next  = (m_owner + 1) % N;
                    m_owner = -1;
                    m_quiet = GAP;
                end
            end else if (m_quiet > 0) begin
                m_quiet = m_quiet - 1;
                if (m_quiet == 0) m_arb = (req != 0);
            end else if (m_arb) begin
                m_arb = 0;
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_next + k) % N]) m_owner = (m_next + k) % N;
                end
                m_stall = 0;
            end else begin
                m_arb = (req != 0);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int qget(input int idx, input logic [7:0] qq [$]);
        return (idx < qq.size()) ? int'(qq[idx]) : -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]       = (q[i].size() > 0) || hold[i];
            req_valid[i] = (q[i].size() > 0);
            req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
            req_last[i]  = (q[i].size() > 0) ? q[i][0][8] : 1'b0;
        end
    endtask

    // One clock: compare at the falling edge, react to transfers after the
    // rising edge.
    task automatic step();
        int fired;
        logic [N-1:0] eg, er;
        logic ev;
        logic [7:0] ed;
        fired = -1;
        @(negedge clk);
        eg = '0; er = '0; ev = 1'b0; ed = 8'h00;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = req_valid[m_owner];
            ed = req_data[8*m_owner +: 8];
            er[m_owner] = tx_ready;
        end
        chk("cycle {grant,ready,valid,data,abort,busy}",
            {grant, req_ready, tx_valid, tx_data, abort, busy},
            {eg, er, ev, ed, m_abort, (m_owner >= 0) || (m_quiet > 0) || m_arb});
        if (stab && prev_vnr) chk("hold_data_under_backpressure", tx_data, prev_data);
        prev_vnr  = stab && tx_valid && !tx_ready;
        prev_data = tx_data;
        if (tx_valid && tx_ready) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) fired = i;
        end
        @(posedge clk);
        #2;
        if (fired >= 0) begin
            seen.push_back(q[fired][0][7:0]);
            void'(q[fired].pop_front());
            fires++;
        end
        cyc++;
        tx_ready = bp ? (cyc % 4 == 0) : 1'b1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        seen.delete();
        fires = 0;
    endtask

    task automatic settle(input string name, input int limit);
        int n;
        n = 0;
        while ((busy || q[0].size() > 0 || q[1].size() > 0 || q[2].size() > 0) && n < limit) begin
            step();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        int n, zr;
        logic [N-1:0] pg;
        logic [7:0] order [$];
        int gaps [$];

        hold = '0; tx_ready = 1'b1; rst = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        drive();
        repeat (3) step();
        chk("reset_outputs {grant,ready,valid,data,abort,busy}",
            {grant, req_ready, tx_valid, tx_data, abort, busy}, '0);
        rst = 1'b0;

        // ---- single frame from requester 0 ----
        q[0].push_back(9'h028); q[0].push_back(9'h05C); q[0].push_back(9'h10A);
        drive();
        step();
        chk("single_arb_cycle {busy,grant}", {busy, grant}, {1'b1, 3'b000});
        step();
        chk("single_grant_two_clocks", grant, 3'b001);
        n = 0;
        while (q[0].size() > 0 && n < 50) begin step(); n++; end
        chk("single_count", seen.size(), 3);
        chk("single_b0", qget(0, seen), 32'h28);
        chk("single_b1", qget(1, seen), 32'h5C);
        chk("single_b2", qget(2, seen), 32'h0A);
        n = 0;
        while (busy && n < 1000) begin n++; step(); end
        chk("single_gap_len", n, GAP);
        chk("single_idle_grant", grant, 3'b000);

        // ---- contention: all three requesting, two-byte frames ----
        do_reset();
        q[0].push_back(9'h010); q[0].push_back(9'h111);
        q[0].push_back(9'h020); q[0].push_back(9'h121);
        q[1].push_back(9'h030); q[1].push_back(9'h131);
        q[2].push_back(9'h040); q[2].push_back(9'h141);
        drive();
        order.delete(); gaps.delete(); zr = 0; pg = '0;
        for (int k = 0; k < 3000 && order.size() < 4; k++) begin
            step();
            if (grant != 0 && pg == 0) begin
                if (order.size() > 0) gaps.push_back(zr);
                order.push_back(8'(grant));
                zr = 0;
            end else if (grant == 0 && order.size() > 0) begin
                zr++;
            end
            pg = grant;
        end
        chk("rr_grant0", qget(0, order), 1);
        chk("rr_grant1", qget(1, order), 2);
        chk("rr_grant2", qget(2, order), 4);
        chk("rr_grant3", qget(3, order), 1);
        // Ownerless stretch between frames = the gap plus the arbitration cycle.
        for (int k = 0; k < 3; k++)
            chk("rr_interframe", (k < gaps.size()) ? gaps[k] : -1, GAP + 1);
        settle("rr_settle_idle", 1000);
        chk("rr_bytes", seen.size(), 8);
        chk("rr_byte2", qget(2, seen), 32'h30);
        chk("rr_byte6", qget(6, seen), 32'h20);

        // ---- backpressure: tx_ready one clock in four, 5-byte frame ----
        do_reset();
        bp = 1; stab = 1;
        for (int b = 1; b <= 5; b++) q[2].push_back({(b == 5), 8'(8'h60 + b)});
        drive();
        n = 0;
        while (q[2].size() > 0 && n < 200) begin step(); n++; end
        bp = 0; stab = 0;
        chk("bp_transfers", fires, 5);
        chk("bp_first", qget(0, seen), 32'h61);
        chk("bp_last", qget(4, seen), 32'h65);
        settle("bp_settle_idle", 1000);

        // ---- stall abort ----
        do_reset();
        hold[0] = 1'b1;
        q[0].push_back(9'h071);
        q[1].push_back(9'h081); q[1].push_back(9'h182);
        drive();
        n = 0;
        while (fires < 1 && n < 50) begin step(); n++; end
        chk("stall_first_byte", qget(0, seen), 32'h71);
        n = 0;
        while (!abort && n < 100) begin n++; step(); end
        chk("stall_abort_delay", n, STALL);
        chk("stall_grant_dropped", grant, 3'b000);
        hold[0] = 1'b0;
        drive();
        n = 0;
        while (grant == 0 && n < 400) begin step(); n++; end
        chk("stall_next_grant", grant, 3'b010);
        settle("stall_settle_idle", 1000);

        // ---- reset in the middle of a frame ----
        do_reset();
        q[1].push_back(9'h091); q[1].push_back(9'h092);
        q[1].push_back(9'h093); q[1].push_back(9'h194);
        drive();
        n = 0;
        while (fires < 2 && n < 50) begin step(); n++; end
        rst = 1'b1;
        #1;
        chk("midreset_outputs_zero {grant,ready,valid,data,abort,busy}",
            {grant, req_ready, tx_valid, tx_data, abort, busy}, '0);
        step();
        step();
        rst = 1'b0;
        n = 0;
        while (grant == 0 && n < 20) begin step(); n++; end
        chk("midreset_regrant_delay", n, 2);
        chk("midreset_regrant", grant, 3'b010);
        settle("midreset_settle_idle", 1000);
        chk("midreset_bytes", fires, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
